// File: rtl/lcd_status_display.sv
// HD44780 16x2 status display driver: power-on wait, fixed init sequence,
// then endless refresh of state name (line 1) and record/play times (line 2).
//
// state   | meaning
// S_PWR   | power-on wait before the first command
// S_INIT  | init commands 0x38, 0x0C, 0x01, 0x06
// S_L1CMD | cursor to line 1 (0x80), inputs snapshotted here
// S_L1CHR | 16 state-name characters
// S_L2CMD | cursor to line 2 (0xC0)
// S_L2CHR | 16 time characters
module lcd_status_display #(
   parameter int PWR_CYC = 12000,
   parameter int EN_CYC  = 1,
   parameter int CMD_CYC = 40,
   parameter int CLR_CYC = 1400
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [2:0] i_state,
   input  logic [5:0] i_record_time,
   input  logic [5:0] i_play_time,
   output logic [7:0] o_LCD_DATA,
   output logic       o_LCD_EN,
   output logic       o_LCD_RS,
   output logic       o_LCD_RW,
   output logic       o_LCD_ON,
   output logic       o_LCD_BLON,
   output logic       o_init_done
);

   localparam int TMAX = (CLR_CYC > CMD_CYC) ?
                         ((CLR_CYC > EN_CYC) ? CLR_CYC : EN_CYC) :
                         ((CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC);
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(PWR_CYC + 1);

   typedef enum logic [2:0] {S_PWR, S_INIT, S_L1CMD, S_L1CHR, S_L2CMD, S_L2CHR} state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          rs_q, rs_d;
   logic          en_q, en_d;
   logic          done_q, done_d;
   logic          on_q;
   logic          snap_en;
   logic [2:0]    snap_state_q;
   logic [5:0]    snap_rec_q, snap_play_q;

   function automatic logic [7:0] txt_char(input logic [127:0] txt, input logic [3:0] idx);
      logic [127:0] sh;
      sh = txt >> {4'd15 - idx, 3'b000};
      return sh[7:0];
   endfunction

   function automatic logic [7:0] init_cmd(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h38;
         4'd1:    return 8'h0C;
         4'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   function automatic logic [7:0] line1_char(input logic [2:0] st, input logic [3:0] idx);
      logic [127:0] txt;
      case (st)
         3'd0:    txt = {"IDLE",        {12{8'h20}}};
         3'd7:    txt = {"I2C INIT",    {8{8'h20}}};
         3'd2:    txt = {"RECORDING",   {7{8'h20}}};
         3'd3:    txt = {"REC PAUSED",  {6{8'h20}}};
         3'd4:    txt = {"PLAYING",     {9{8'h20}}};
         3'd5:    txt = {"PLAY PAUSED", {5{8'h20}}};
         default: txt = {"UNKNOWN",     {9{8'h20}}};
      endcase
      return txt_char(txt, idx);
   endfunction

   // Each time is shown as two decimal digits with the leading zero kept.
   function automatic logic [7:0] line2_char(input logic [5:0] rec, input logic [5:0] ply,
                                             input logic [3:0] idx);
      logic [7:0]   rt, ro, pt, po;
      logic [127:0] txt;
      rt  = 8'h30 + 8'(rec / 6'd10);
      ro  = 8'h30 + 8'(rec % 6'd10);
      pt  = 8'h30 + 8'(ply / 6'd10);
      po  = 8'h30 + 8'(ply % 6'd10);
      txt = {"REC ", rt, ro, "  PLAY ", pt, po, " "};
      return txt_char(txt, idx);
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_PWR;
         phase_q      <= PH_SETUP;
         pwr_cnt_q    <= '0;
         tmr_q        <= '0;
         idx_q        <= '0;
         data_q       <= 8'h00;
         rs_q         <= 1'b0;
         en_q         <= 1'b0;
         done_q       <= 1'b0;
         on_q         <= 1'b0;
         snap_state_q <= '0;
         snap_rec_q   <= '0;
         snap_play_q  <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         pwr_cnt_q <= pwr_cnt_d;
         tmr_q     <= tmr_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         rs_q      <= rs_d;
         en_q      <= en_d;
         done_q    <= done_d;
         on_q      <= 1'b1;
         if (snap_en) begin
            snap_state_q <= i_state;
            snap_rec_q   <= i_record_time;
            snap_play_q  <= i_play_time;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      pwr_cnt_d = pwr_cnt_q;
      tmr_d     = tmr_q;
      idx_d     = idx_q;
      data_d    = data_q;
      rs_d      = rs_q;
      en_d      = 1'b0;
      done_d    = done_q;
      snap_en   = 1'b0;

      if (state_q == S_PWR) begin
         if (pwr_cnt_q == PW'(PWR_CYC - 1)) begin
            state_d   = S_INIT;
            phase_d   = PH_SETUP;
            pwr_cnt_d = '0;
            idx_d     = 4'd0;
            data_d    = init_cmd(4'd0);
            rs_d      = 1'b0;
         end else begin
            pwr_cnt_d = pwr_cnt_q + 1'b1;
         end
      end else begin
         case (phase_q)
            PH_SETUP: begin
               phase_d = PH_PULSE;
               en_d    = 1'b1;
               tmr_d   = TW'(EN_CYC - 1);
               snap_en = (state_q == S_L1CMD);
            end
            PH_PULSE: begin
               if (tmr_q == '0) begin
                  phase_d = PH_WAIT;
                  // The clear command needs the long settle time.
                  tmr_d   = (!rs_q && data_q == 8'h01) ? TW'(CLR_CYC - 1) : TW'(CMD_CYC - 1);
               end else begin
                  en_d  = 1'b1;
                  tmr_d = tmr_q - 1'b1;
               end
            end
            PH_WAIT: begin
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - 1'b1;
               end else begin
                  phase_d = PH_SETUP;
                  case (state_q)
                     S_INIT: begin
                        if (idx_q == 4'd3) begin
                           state_d = S_L1CMD;
                           done_d  = 1'b1;
                           data_d  = 8'h80;
                           rs_d    = 1'b0;
                        end else begin
                           idx_d  = idx_q + 4'd1;
                           data_d = init_cmd(idx_q + 4'd1);
                        end
                     end
                     S_L1CMD: begin
                        state_d = S_L1CHR;
                        idx_d   = 4'd0;
                        rs_d    = 1'b1;
                        data_d  = line1_char(snap_state_q, 4'd0);
                     end
                     S_L1CHR: begin
                        if (idx_q == 4'd15) begin
                           state_d = S_L2CMD;
                           rs_d    = 1'b0;
                           data_d  = 8'hC0;
                        end else begin
                           idx_d  = idx_q + 4'd1;
                           data_d = line1_char(snap_state_q, idx_q + 4'd1);
                        end
                     end
                     S_L2CMD: begin
                        state_d = S_L2CHR;
                        idx_d   = 4'd0;
                        rs_d    = 1'b1;
                        data_d  = line2_char(snap_rec_q, snap_play_q, 4'd0);
                     end
                     S_L2CHR: begin
                        if (idx_q == 4'd15) begin
                           state_d = S_L1CMD;
                           rs_d    = 1'b0;
                           data_d  = 8'h80;
                        end else begin
                           idx_d  = idx_q + 4'd1;
                           data_d = line2_char(snap_rec_q, snap_play_q, idx_q + 4'd1);
                        end
                     end
                     default: state_d = S_PWR;
                  endcase
               end
            end
            default: phase_d = PH_SETUP;
         endcase
      end
   end

   assign o_LCD_DATA  = data_q;
   assign o_LCD_EN    = en_q;
   assign o_LCD_RS    = rs_q;
   assign o_LCD_RW    = 1'b0;
   assign o_LCD_ON    = on_q;
   assign o_LCD_BLON  = on_q;
   assign o_init_done = done_q;

endmodule

// File: tb/tb_lcd_status_display.sv
// Scoreboard bench for lcd_status_display: expected writes are queued from a
// text-level display model and checked at every EN rising edge.
`timescale 1ns/1ps
module tb_lcd_status_display;
   localparam int PWR_CYC = 12000;
   localparam int EN_CYC  = 1;
   localparam int CMD_CYC = 40;
   localparam int CLR_CYC = 1400;
   localparam int FRAME   = 34;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] st = 3'd2;
   logic [5:0] rec = 6'd37;
   logic [5:0] ply = 6'd0;
   logic [7:0] lcd_data;
   logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, init_done;

   always #5 clk = ~clk;

   lcd_status_display #(
      .PWR_CYC(PWR_CYC), .EN_CYC(EN_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_state(st), .i_record_time(rec), .i_play_time(ply),
      .o_LCD_DATA(lcd_data), .o_LCD_EN(lcd_en), .o_LCD_RS(lcd_rs), .o_LCD_RW(lcd_rw),
      .o_LCD_ON(lcd_on), .o_LCD_BLON(lcd_blon), .o_init_done(init_done)
   );

   typedef struct {
      logic       rs;
      logic [7:0] data;
      logic       done;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  wr_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic string line1_text(input int s);
      string t;
      case (s)
         0:       t = "IDLE";
         7:       t = "I2C INIT";
         2:       t = "RECORDING";
         3:       t = "REC PAUSED";
         4:       t = "PLAYING";
         5:       t = "PLAY PAUSED";
         default: t = "UNKNOWN";
      endcase
      while (t.len() < 16) t = {t, " "};
      return t;
   endfunction

   task automatic push_w(input logic rs, input logic [7:0] d, input logic done);
      wr_t w;
      w.rs = rs; w.data = d; w.done = done;
      exp_q.push_back(w);
   endtask

   task automatic push_init();
      push_w(1'b0, 8'h38, 1'b0);
      push_w(1'b0, 8'h0C, 1'b0);
      push_w(1'b0, 8'h01, 1'b0);
      push_w(1'b0, 8'h06, 1'b0);
   endtask

   task automatic push_frame(input int s, input int r, input int p);
      string l1, l2;
      l1 = line1_text(s);
      l2 = $sformatf("REC %02d  PLAY %02d ", r, p);
      push_w(1'b0, 8'h80, 1'b1);
      for (int i = 0; i < 16; i++) push_w(1'b1, l1[i], 1'b1);
      push_w(1'b0, 8'hC0, 1'b1);
      for (int i = 0; i < 16; i++) push_w(1'b1, l2[i], 1'b1);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Monitor: write protocol timing plus scoreboard comparison on each EN rise.
   initial begin
      logic       prev_en, prev_rs, prev_done, seen80;
      logic [7:0] prev_data;
      int         hi_cnt, last_rise, prev_dur, done_rise;
      wr_t        w;
      prev_en = 0; prev_rs = 0; prev_done = 0; seen80 = 0; prev_data = 0;
      hi_cnt = 0; last_rise = 0; prev_dur = 0; done_rise = -1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            wr_cnt = 0; prev_en = 0; prev_rs = lcd_rs; prev_data = lcd_data;
            prev_done = 0; seen80 = 0; hi_cnt = 0; done_rise = -1;
         end else begin
            if (init_done && !prev_done) done_rise = cyc;
            if (lcd_en && !prev_en) begin
               chk($sformatf("setup_stable_w%0d", wr_cnt), {prev_rs, prev_data}, {lcd_rs, lcd_data});
               if (wr_cnt == 0) chk("power_wait_first_en", cyc, PWR_CYC + 1);
               else chk($sformatf("write_period_w%0d", wr_cnt), cyc - last_rise, prev_dur);
               chk("on_blon_rw", {lcd_on, lcd_blon, lcd_rw}, 3'b110);
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_write: got rs=%0d data=0x%0h expected none", lcd_rs, lcd_data);
               end else begin
                  w = exp_q.pop_front();
                  chk($sformatf("rs_w%0d", wr_cnt), lcd_rs, w.rs);
                  chk($sformatf("data_w%0d", wr_cnt), lcd_data, w.data);
                  chk($sformatf("init_done_w%0d", wr_cnt), init_done, w.done);
               end
               if (!seen80 && !lcd_rs && lcd_data == 8'h80) begin
                  seen80 = 1;
                  chk("init_done_rise_cycle", done_rise, cyc - 1);
               end
               prev_dur  = 1 + EN_CYC + ((!lcd_rs && lcd_data == 8'h01) ? CLR_CYC : CMD_CYC);
               last_rise = cyc;
               wr_cnt++;
            end
            if (lcd_en) hi_cnt = prev_en ? hi_cnt + 1 : 1;
            if (!lcd_en && prev_en) chk("en_width", hi_cnt, EN_CYC);
            prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data; prev_done = init_done;
         end
      end
   end

   task automatic wait_writes(input int n, input string what);
      int budget;
      budget = 20000;
      while (wr_cnt < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({"reached_", what}, (wr_cnt >= n) ? 1 : 0, 1);
   endtask

   initial begin
      int budget;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_outputs", {lcd_data, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, init_done}, 14'h0);
      push_init();
      push_frame(2, 37, 0);
      #1 rst_n = 1'b1;

      wait_writes(5, "frame0");
      st = 3'd1; rec = 6'd63; ply = 6'd9;
      push_frame(1, 63, 9);

      for (int k = 1; k <= 4; k++) begin
         wait_writes(4 + FRAME * k + 1, $sformatf("frame%0d", k));
         st  = 3'($urandom_range(7, 0));
         rec = 6'($urandom_range(63, 0));
         ply = 6'($urandom_range(63, 0));
         push_frame(st, rec, ply);
      end

      wait_writes(4 + FRAME * 5 + 1, "frame5");
      st  = 3'd4;
      rec = 6'($urandom_range(63, 0));
      ply = 6'($urandom_range(63, 0));
      push_frame(4, rec, ply);
      wait_writes(4 + FRAME * 6 + 1 + 3 + 1, "frame6_char3");
      st = 3'd5;
      push_frame(5, rec, ply);

      wait_writes(4 + FRAME * 7 + 22 + 3, "frame7_line2");
      budget = 100;
      while (budget > 0) begin
         @(posedge clk);
         #1;
         if (lcd_en) break;
         budget--;
      end
      chk("en_high_before_reset", lcd_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {lcd_data, lcd_en, lcd_rs, lcd_on, lcd_blon, init_done}, 13'h0);
      exp_q.delete();
      push_init();
      push_frame(5, rec, ply);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      wait_writes(4 + FRAME, "post_reset_frame");
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_status_display.md
# lcd_status_display

Drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode to show the recorder's top-level status. It sits downstream of the recorder top level and consumes its `o_state`, `o_record_time` and `o_play_time` outputs. After power-up it runs a fixed init sequence, then refreshes both display lines forever. Line 1 shows the state name; line 2 shows both times as two decimal digits each.

## Interface
- `PWR_CYC`, default 12000: power-on wait in cycles (15 ms at 800 kHz).
- `EN_CYC`, default 1: cycles `o_LCD_EN` is held high per write.
- `CMD_CYC`, default 40: post-write wait for normal commands and characters.
- `CLR_CYC`, default 1400: post-write wait after the clear command 0x01.
- `i_clk`, in, 1: single clock (800 kHz LCD clock). All logic is on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_state`, in, 3: top-level state code.
- `i_record_time`, in, 6: record time, 0–63.
- `i_play_time`, in, 6: play time, 0–63.
- `o_LCD_DATA`, out, 8: LCD data bus. Output only; the LCD is never read.
- `o_LCD_EN`, out, 1: LCD enable strobe.
- `o_LCD_RS`, out, 1: 0 = command, 1 = character data.
- `o_LCD_RW`, out, 1: constant 0.
- `o_LCD_ON`, out, 1: 1 whenever `i_rst_n` = 1.
- `o_LCD_BLON`, out, 1: 1 whenever `i_rst_n` = 1.
- `o_init_done`, out, 1: high once the init sequence has completed; stays high until reset.

## Operation

**States**
- `S_PWR`: count `PWR_CYC` cycles, then go to `S_INIT`.
- `S_INIT`: write commands 0x38, 0x0C, 0x01, 0x06 in that order. Then set `o_init_done`, go to `S_L1CMD`.
- `S_L1CMD`: snapshot inputs (see below), write command 0x80, go to `S_L1CHR`.
- `S_L1CHR`: write 16 characters, index 0..15, then go to `S_L2CMD`.
- `S_L2CMD`: write command 0xC0, go to `S_L2CHR`.
- `S_L2CHR`: write 16 characters, then go back to `S_L1CMD`. The refresh loop never terminates.

**Write sub-sequence (every command and character)**
- Phase SETUP, 1 cycle: drive `o_LCD_RS` and `o_LCD_DATA`, `o_LCD_EN` = 0.
- Phase PULSE, `EN_CYC` cycles: `o_LCD_EN` = 1.
- Phase WAIT: `o_LCD_EN` = 0 for `CMD_CYC` cycles, or `CLR_CYC` cycles after 0x01.
- `o_LCD_RS` and `o_LCD_DATA` hold unchanged from SETUP through the end of WAIT.
- The first cycle after WAIT is the SETUP cycle of the next write.

**Snapshot**
- In the SETUP cycle of each 0x80 write, register `i_state`, `i_record_time` and `i_play_time`.
- Both lines of that frame use only the snapshot. Input changes mid-frame appear in the next frame.

**Line 1 text** (ASCII, left-justified, space-padded to 16 characters), selected by snapshot state:
- 0: "IDLE"
- 7: "I2C INIT"
- 2: "RECORDING"
- 3: "REC PAUSED"
- 4: "PLAYING"
- 5: "PLAY PAUSED"
- 1 or 6: "UNKNOWN"

**Line 2 text**, always exactly 16 characters: "REC tt  PLAY pp ".
- `tt` is at positions 4–5 and is the record time; `pp` is at positions 13–14 and is the play time.
- Tens digit = value / 10 (range 0–6). Ones digit = value % 10. Each digit is sent as 0x30 + digit.
- The leading zero is always shown: 5 → "05", 63 → "63".

**Reset mid-operation**
- Asserting `i_rst_n` low at any point aborts the current write immediately.
- The next release restarts from `S_PWR`, including the full power-on wait.

## Timing
- Reset values:
  - `o_LCD_DATA` = 0x00
  - `o_LCD_EN` = 0
  - `o_LCD_RS` = 0
  - `o_LCD_RW` = 0
  - `o_LCD_ON` = 0
  - `o_LCD_BLON` = 0
  - `o_init_done` = 0
  - state = `S_PWR`, all counters = 0
- First SETUP cycle (data 0x38, RS = 0) occurs on cycle `PWR_CYC` after reset release.
- Each write lasts `W` = 1 + `EN_CYC` + `CMD_CYC` cycles (42 at defaults). The 0x01 write uses `CLR_CYC` instead of `CMD_CYC`.
- `o_init_done` rises on the cycle after the 0x06 WAIT completes. This is the same cycle as the 0x80 SETUP.
- One refresh frame = 34 writes = 34·`W` cycles (1428 at defaults).
- `o_LCD_EN` never goes high in the same cycle that `o_LCD_DATA` or `o_LCD_RS` changes.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset and power wait:** hold reset, release → `o_LCD_EN` stays 0 for 12000 cycles; next write shows RS = 0, DATA = 0x38; `o_LCD_ON` = 1 after release.
- **Init sequence:** capture bytes on each `o_LCD_EN` rising edge → 0x38, 0x0C, 0x01, 0x06. Gap from 0x01 EN-fall to 0x06 SETUP = 1400 cycles. Then `o_init_done` = 1.
- **Frame content:** state = 2, record = 37, play = 0 → line 1 = "RECORDING" + 7 spaces after 0x80; line 2 = "REC 37  PLAY 00 " after 0xC0.
- **Boundary digits and unknown state:** state = 1, record = 63, play = 9 → line 1 = "UNKNOWN"; line 2 = "REC 63  PLAY 09 ".
- **Snapshot:** change state 4 → 5 during line-1 character 3 → current frame line 1 = "PLAYING"; next frame line 1 = "PLAY PAUSED".
- **Reset mid-write:** assert reset while `o_LCD_EN` = 1 during line 2 → EN drops to 0 asynchronously. After release, 12000 idle cycles, then 0x38 is written again.
